// File: rtl/fetch_pack_tx_if.sv
// Fetch-line input and aligned-table output bundle for fetch_pack_tx.
// slave = the packer, master = the fetch unit / queue side driving it.
interface fetch_pack_tx_if;
  logic         i_flush;
  logic         i_fetchValid;
  logic         o_fetchReady;
  logic [31:0]  i_fetchPC;
  logic [511:0] i_fetchLine;
  logic         i_predTaken;
  logic [3:0]   i_predSlot;
  logic         o_valid;
  logic         i_ready;
  logic [639:0] o_alignedInstructionTable;
  logic [3:0]   o_cutPosition;
  logic         o_taken;

  modport slave (
    input  i_flush, i_fetchValid, i_fetchPC, i_fetchLine, i_predTaken, i_predSlot, i_ready,
    output o_fetchReady, o_valid, o_alignedInstructionTable, o_cutPosition, o_taken
  );

  modport master (
    output i_flush, i_fetchValid, i_fetchPC, i_fetchLine, i_predTaken, i_predSlot, i_ready,
    input  o_fetchReady, o_valid, o_alignedInstructionTable, o_cutPosition, o_taken
  );
endinterface

// File: rtl/fetch_pack_tx.sv
// Packs live slots of a 64-byte fetch line into a 10-entry {PC,instr} table; lines over 10 slots go out as two beats.
// Registered outputs, one beat per cycle; FETCH_PACK_PERF_EN adds saturating beat/stall counters.
module fetch_pack_tx (
  input  logic            clk,
  input  logic            rst,
  fetch_pack_tx_if.slave  bus
`ifdef FETCH_PACK_PERF_EN
  ,
  output logic [31:0]     o_beatCount,
  output logic [31:0]     o_stallCount
`endif
);

  localparam int ENTRIES    = 10;
  localparam int LINE_WORDS = 16;

  typedef enum logic [1:0] {IDLE, SEND, SEND_HI} state_t;

  state_t                  state_q, state_d;
  logic [ENTRIES*64-1:0]   table_q, table_d;
  logic [3:0]              cut_q, cut_d;
  logic                    taken_q, taken_d;
  logic [LINE_WORDS*32-1:0] line_q, line_d;
  logic [25:0]             pchi_q, pchi_d;
  logic [4:0]              b2_q, b2_d;
  logic [4:0]              n2_q, n2_d;
  logic                    taken2_q, taken2_d;

  logic [4:0] s, e, n, n_m1, n2_m1, first_cnt;
  logic       pred_use, fetch_ready, accept, valid;
  logic       unused_pc_lsbs;

  assign unused_pc_lsbs = ^bus.i_fetchPC[1:0];

  assign s         = {1'b0, bus.i_fetchPC[5:2]};
  assign pred_use  = bus.i_predTaken && ({1'b0, bus.i_predSlot} >= s);
  assign e         = pred_use ? {1'b0, bus.i_predSlot} : 5'd15;
  assign n         = e - s + 5'd1;
  assign n_m1      = n - 5'd1;
  assign n2_m1     = n2_q - 5'd1;
  assign first_cnt = (n > 5'd10) ? 5'd10 : n;

  assign valid       = (state_q != IDLE);
  assign fetch_ready = rst && !bus.i_flush &&
                       ((state_q == IDLE) || ((state_q == SEND) && bus.i_ready));
  assign accept      = bus.i_fetchValid && fetch_ready;

  // Entry k carries slot b+k; entries at or beyond cnt stay zero.
  function automatic logic [ENTRIES*64-1:0] pack_beat(
    input logic [LINE_WORDS*32-1:0] line,
    input logic [25:0]              pchi,
    input logic [4:0]               b,
    input logic [4:0]               cnt
  );
    logic [ENTRIES*64-1:0] t;
    logic [4:0]            slot;
    t = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      slot = b + 5'(k);
      if (5'(k) < cnt) begin
        t[k*64 +: 64] = {pchi, slot[3:0], 2'b00, line[{slot[3:0], 5'b0} +: 32]};
      end
    end
    return t;
  endfunction

  always_comb begin
    state_d  = state_q;
    table_d  = table_q;
    cut_d    = cut_q;
    taken_d  = taken_q;
    line_d   = line_q;
    pchi_d   = pchi_q;
    b2_d     = b2_q;
    n2_d     = n2_q;
    taken2_d = taken2_q;

    if (bus.i_flush) begin
      state_d = IDLE;
      table_d = '0;
      cut_d   = '0;
      taken_d = 1'b0;
    end else if (accept) begin
      table_d = pack_beat(bus.i_fetchLine, bus.i_fetchPC[31:6], s, first_cnt);
      if (n > 5'd10) begin
        state_d  = SEND_HI;
        cut_d    = 4'd9;
        taken_d  = 1'b0;
        line_d   = bus.i_fetchLine;
        pchi_d   = bus.i_fetchPC[31:6];
        b2_d     = s + 5'd10;
        n2_d     = n - 5'd10;
        taken2_d = pred_use;
      end else begin
        state_d = SEND;
        cut_d   = n_m1[3:0];
        taken_d = pred_use;
      end
    end else begin
      case (state_q)
        SEND: begin
          if (bus.i_ready) begin
            state_d = IDLE;
            table_d = '0;
            cut_d   = '0;
            taken_d = 1'b0;
          end
        end
        SEND_HI: begin
          if (bus.i_ready) begin
            state_d = SEND;
            table_d = pack_beat(line_q, pchi_q, b2_q, n2_q);
            cut_d   = n2_m1[3:0];
            taken_d = taken2_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      table_q  <= '0;
      cut_q    <= '0;
      taken_q  <= 1'b0;
      line_q   <= '0;
      pchi_q   <= '0;
      b2_q     <= '0;
      n2_q     <= '0;
      taken2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      table_q  <= table_d;
      cut_q    <= cut_d;
      taken_q  <= taken_d;
      line_q   <= line_d;
      pchi_q   <= pchi_d;
      b2_q     <= b2_d;
      n2_q     <= n2_d;
      taken2_q <= taken2_d;
    end
  end

  assign bus.o_fetchReady              = fetch_ready;
  assign bus.o_valid                   = valid;
  assign bus.o_alignedInstructionTable = table_q;
  assign bus.o_cutPosition             = cut_q;
  assign bus.o_taken                   = taken_q;

`ifdef FETCH_PACK_PERF_EN
  logic [31:0] beat_cnt_q, stall_cnt_q;

  // Flush does not clear these; only reset does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (valid && bus.i_ready && (beat_cnt_q != '1)) begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end
      if (valid && !bus.i_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign o_beatCount  = beat_cnt_q;
  assign o_stallCount = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_pack_tx.md
Name: fetch_pack_tx

Overview:
- Transmit side of the aligned-instruction interface that feeds the instruction queue.
- Takes one 64-byte fetch line per handshake plus fetch PC and branch prediction, and extracts the live instruction slots.
- Packs them as {PC, instr} 64-bit entries into a 10-entry aligned table with a cut position (index of the last valid entry).
- Sends the table over a registered valid/ready handshake; a line with more than 10 live slots is split into two beats.

Parameters:
- ENTRIES, 10, entries per transmitted table (fixed at 10; sets all table widths).
- LINE_WORDS, 16, 32-bit instruction words per fetch line.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- i_flush  input  1  redirect; discards all buffered and in-flight state
- i_fetchValid  input  1  fetch line offered
- o_fetchReady  output  1  line accepted on posedge when i_fetchValid && o_fetchReady
- i_fetchPC  input  32  PC of first live instruction; PC[5:2] is the start slot s
- i_fetchLine  input  512  word w at [w*32+:32]
- i_predTaken  input  1  predicted-taken branch in line
- i_predSlot  input  4  slot of that branch
- o_valid  output  1  table valid
- i_ready  input  1  queue accepts the table when o_valid && i_ready
- o_alignedInstructionTable  output  640  entry k at [k*64+:64] = {PC[31:0], instr[31:0]}; unused entries zero
- o_cutPosition  output  4  index of last valid entry, 0..9
- o_taken  output  1  beat contains the predicted-taken slot

Behaviour:
- Reset (rst low, async): o_valid=0, table=0, o_cutPosition=0, o_taken=0, FSM=IDLE. o_fetchReady=0 while reset is asserted; 1 in the first cycle after release.
- Slot range:
  - e = (i_predTaken && i_predSlot>=s) ? i_predSlot : 15.
  - A prediction with i_predSlot<s is ignored.
  - n = e-s+1, range 1..16. All arithmetic is 5-bit; no wrap.
- Entry k of a beat starting at slot b = {i_fetchPC[31:6], (b+k)[3:0], 2'b00, word(b+k)}.
- FSM states:
  - IDLE: output empty.
  - SEND: one beat held.
  - SEND_HI: first of two beats held, second pending in a hold register.
- Accept on posedge, from IDLE, or from SEND when i_ready is high the same cycle (back-to-back):
  - n<=10: load beat b=s, cut=n-1, o_taken=predicted-taken-used; go to SEND.
  - n>10: load beat b=s, cut=9, o_taken=0; store line, s+10, n-10 and the prediction; go to SEND_HI.
- SEND_HI with i_ready: load second beat b=s+10, cut=n-11, o_taken=prediction used; go to SEND. o_fetchReady=0 in SEND_HI.
- o_fetchReady = (state==IDLE) || (state==SEND && i_ready) while not flushing. This is a combinational path from i_ready.
- Latency: line accepted at edge N gives o_valid=1 from N (registered outputs visible after edge N); one beat per cycle at full throughput.
- Stall: while o_valid && !i_ready, all outputs hold bit-stable.
- Drain: SEND with i_ready and no new line goes to IDLE, o_valid=0 next cycle.
- i_flush (synchronous, highest priority):
  - Next state IDLE; o_valid=0; pending second beat dropped.
  - o_fetchReady=0 that cycle; a line offered in the flush cycle is not accepted.
  - A beat handshaken in the flush cycle counts as delivered.
- Reset mid-transfer: immediate return to reset values; no partial beat survives.

Optional Feature:
- Macro FETCH_PACK_PERF_EN.
- When defined, adds outputs o_beatCount[31:0] and o_stallCount[31:0]:
  - o_beatCount: beats handshaken.
  - o_stallCount: cycles with o_valid && !i_ready.
  - Both saturate at all-ones and clear on reset only (not on flush).
- When undefined: no ports, no counter logic; all other behaviour identical.

Test Plan:
- PC=0x1000_0020 (s=8), no prediction, i_ready=1 -> one beat: cut=7, entry0={0x1000_0020, word8}, entry7={0x1000_003C, word15}, entries 8-9 zero, o_taken=0.
- PC=0x2000_0000 (s=0), no prediction -> beat1 cut=9 (slots 0-9), o_fetchReady=0; beat2 cut=5 (slots 10-15, entry0 PC=0x2000_0028); then IDLE.
- s=4, i_predTaken=1, predSlot=6 -> one beat, cut=2, o_taken=1; repeat with predSlot=2 -> prediction ignored, cut=11 split into 9 then 1 beat(s) per rule (cut 9, cut 1), o_taken=0.
- Hold i_ready=0 for 5 cycles with o_valid=1 -> outputs bit-stable, no new accept; with FETCH_PACK_PERF_EN, o_stallCount=5.
- i_flush asserted in SEND_HI with i_fetchValid=1 -> next cycle o_valid=0, IDLE; the offered line is not accepted and is accepted in the following cycle.
- rst pulsed low mid-SEND_HI, async to clk -> o_valid=0 and table=0 immediately; first beat after release comes from a new accept.
